// File: rtl/rf_dump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
// The index header byte (RF_DUMP_INDEX_EN builds) is the register index zero-extended to HDR_W.
package rf_dump_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } state_e;

  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_BYTES  = DEF_DATA_W / 8;

  // Width of the index header byte; the index occupies its low bits.
  localparam int unsigned HDR_W = 8;

endpackage

// File: rtl/rf_dump_ser.sv
// Shadow word and valid/ready byte serializer, most significant byte first.
// With RF_DUMP_INDEX_EN defined, each word is preceded by its index header byte.
module rf_dump_ser
  import rf_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BYTES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              send,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [HDR_W-1:0]  hdr,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              last_byte
);

`ifdef RF_DUMP_INDEX_EN
  localparam int unsigned NumSlots = BYTES + 1;
`else
  localparam int unsigned NumSlots = BYTES;
`endif
  localparam int unsigned CntW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlots - 1);

  logic [DATA_W-1:0] shadow_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   data_idx;
  logic [7:0]        data_byte;
  logic [7:0]        cur_byte;
  logic              handshake;

  assign handshake = send & out_ready;
  assign last_byte = handshake & (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      shadow_q <= reg_data;
      cnt_q    <= '0;
    end else if (handshake && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

`ifdef RF_DUMP_INDEX_EN
  // Slot 0 is the header, so data bytes sit one slot later.
  assign data_idx = cnt_q - CntW'(1);
  assign cur_byte = (cnt_q == '0) ? hdr : data_byte;
`else
  logic unused_hdr;
  assign unused_hdr = ^hdr;
  assign data_idx   = cnt_q;
  assign cur_byte   = data_byte;
`endif

  always_comb begin
    data_byte = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (data_idx == CntW'(i)) data_byte = shadow_q[DATA_W-1-8*i -: 8];
    end
  end

  assign out_valid = send;
  assign out_data  = send ? cur_byte : 8'h00;

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a register index range on the RF observation port and streams each word as bytes.
// Define RF_DUMP_INDEX_EN to prefix every word with a one-byte register index header.
module rf_dump_reader
  import rf_dump_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BYTES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] first,
  input  logic [REG_AW-1:0] last,
  input  logic              abort,
  output logic [REG_AW-1:0] reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] sel_q, sel_d;
  logic [REG_AW-1:0] last_q, last_d;
  logic              err_q, err_d;
  logic              load, send, last_byte;
  logic [HDR_W-1:0]  hdr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (abort) begin
      // Abort also swallows a start presented in the same cycle.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (first <= last) begin
              sel_d   = first;
              last_d  = last;
              state_d = StLoad;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StLoad: state_d = StSend;
        StSend: begin
          if (last_byte) begin
            // Compare before incrementing so a full-range dump never wraps.
            if (sel_q == last_q) begin
              state_d = StDone;
            end else begin
              sel_d   = sel_q + REG_AW'(1);
              state_d = StLoad;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign load    = (state_q == StLoad);
  assign send    = (state_q == StSend);
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err     = err_q;
  assign reg_sel = sel_q;
  assign hdr     = HDR_W'(sel_q);

  rf_dump_ser #(
    .DATA_W(DATA_W),
    .BYTES (BYTES)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .send     (send),
    .reg_data (reg_data),
    .hdr      (hdr),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .last_byte(last_byte)
  );

endmodule
